serial_adder: RTL and testbench



---
 rtl/serial_adder_if.sv | 58 +++++
 rtl/serial_adder.sv | 141 ++++++++++++++
 tb/tb_serial_adder.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// serial_adder_if -- operand/result stream bundle for serial_adder.
//
// Operand stream (upstream -> adder):
//   istream_val  operands valid
//   istream_rdy  adder can accept operands
//   istream_in0  operand A (nbits)
//   istream_in1  operand B (nbits)
//   istream_cin  carry-in, present only when SERIAL_ADDER_CIN_EN is defined
// Result stream (adder -> downstream):
//   ostream_val  result valid
//   ostream_rdy  consumer accepts result
//   ostream_sum  (A + B [+ cin]) mod 2^nbits
//   ostream_cout carry out of bit nbits-1
//
// Modports:
//   master  the environment: drives operands and the result-ready
//   slave   the adder itself
//
// Build option: SERIAL_ADDER_CIN_EN adds istream_cin.

interface serial_adder_if #(
  parameter int nbits = 8
);
  logic             istream_val;
  logic             istream_rdy;
  logic [nbits-1:0] istream_in0;
  logic [nbits-1:0] istream_in1;
`ifdef SERIAL_ADDER_CIN_EN
  logic             istream_cin;
`endif
  logic             ostream_val;
  logic             ostream_rdy;
  logic [nbits-1:0] ostream_sum;
  logic             ostream_cout;

`ifdef SERIAL_ADDER_CIN_EN
  modport master (
    output istream_val, istream_in0, istream_in1, istream_cin, ostream_rdy,
    input  istream_rdy, ostream_val, ostream_sum, ostream_cout
  );

  modport slave (
    input  istream_val, istream_in0, istream_in1, istream_cin, ostream_rdy,
    output istream_rdy, ostream_val, ostream_sum, ostream_cout
  );
`else
  modport master (
    output istream_val, istream_in0, istream_in1, ostream_rdy,
    input  istream_rdy, ostream_val, ostream_sum, ostream_cout
  );

  modport slave (
    input  istream_val, istream_in0, istream_in1, ostream_rdy,
    output istream_rdy, ostream_val, ostream_sum, ostream_cout
  );
`endif

endinterface

// File: rtl/serial_adder.sv
// serial_adder -- bit-serial ripple adder.
//
// Takes two nbits operands over a val/rdy stream, adds them one bit per
// cycle (LSB first) through a single one-bit full adder with the carry kept
// in a flop, then presents the full sum and carry-out over a val/rdy stream.
// Throughput is one result every nbits+2 cycles at best.
//
// Ports:
//   clk    clock, all state updates on the rising edge
//   reset  synchronous, active-high; abandons any transaction in flight
//   s      serial_adder_if.slave (operand stream in, result stream out)
//
// Parameters:
//   nbits  operand/result width, 1..32
//
// Build option: define SERIAL_ADDER_CIN_EN to add istream_cin; the carry
// flop then loads it on accept so the result is A+B+cin. Undefined, the
// carry starts at 0. Timing is identical either way.

// One-bit full adder cell.
module serial_adder_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for operands; result stream idle
// CALC  | one operand bit pair added per cycle, nbits cycles in total
// DONE  | result valid and held until the consumer takes it
module serial_adder #(
  parameter int nbits = 8
) (
  input  logic            clk,
  input  logic            reset,
  serial_adder_if.slave   s
);

  localparam int cnt_w = (nbits > 1) ? $clog2(nbits) : 1;
  localparam logic [cnt_w-1:0] last_count = cnt_w'(nbits - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [nbits-1:0] a_reg;
  logic [nbits-1:0] b_reg;
  logic [nbits-1:0] sum_reg;
  logic             carry_reg;
  logic [cnt_w-1:0] count;
  logic             istream_rdy_reg;
  logic             ostream_val_reg;

  logic fa_sum;
  logic fa_cout;
  logic cin_load;

`ifdef SERIAL_ADDER_CIN_EN
  assign cin_load = s.istream_cin;
`else
  assign cin_load = 1'b0;
`endif

  serial_adder_fa u_fa (
    .a    (a_reg[0]),
    .b    (b_reg[0]),
    .cin  (carry_reg),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      a_reg           <= '0;
      b_reg           <= '0;
      sum_reg         <= '0;
      carry_reg       <= 1'b0;
      count           <= '0;
      istream_rdy_reg <= 1'b1;
      ostream_val_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s.istream_val) begin
            a_reg           <= s.istream_in0;
            b_reg           <= s.istream_in1;
            sum_reg         <= '0;
            carry_reg       <= cin_load;
            count           <= '0;
            istream_rdy_reg <= 1'b0;
            state           <= CALC;
          end
        end

        CALC: begin
          // New sum bit enters at the MSB; after nbits shifts the LSB
          // computed first has walked down to bit 0.
          sum_reg   <= (sum_reg >> 1) | (nbits'(fa_sum) << (nbits - 1));
          carry_reg <= fa_cout;
          a_reg     <= a_reg >> 1;
          b_reg     <= b_reg >> 1;
          count     <= count + 1'b1;
          if (count == last_count) begin
            ostream_val_reg <= 1'b1;
            state           <= DONE;
          end
        end

        DONE: begin
          if (s.ostream_rdy) begin
            ostream_val_reg <= 1'b0;
            istream_rdy_reg <= 1'b1;
            state           <= IDLE;
          end
        end

        default: begin
          ostream_val_reg <= 1'b0;
          istream_rdy_reg <= 1'b1;
          state           <= IDLE;
        end
      endcase
    end
  end

  assign s.istream_rdy  = istream_rdy_reg;
  assign s.ostream_val  = ostream_val_reg;
  assign s.ostream_sum  = sum_reg;
  assign s.ostream_cout = carry_reg;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder -- self-checking bench for serial_adder (nbits = 8).
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_serial_adder;

  localparam int NB = 8;
`ifdef SERIAL_ADDER_CIN_EN
  localparam bit CIN_EN = 1'b1;
`else
  localparam bit CIN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic tb_cin;
  int   checks = 0;
  int   failures = 0;

  serial_adder_if #(.nbits(NB)) ifc ();

  serial_adder #(.nbits(NB)) dut (
    .clk   (clk),
    .reset (reset),
    .s     (ifc)
  );

`ifdef SERIAL_ADDER_CIN_EN
  assign ifc.istream_cin = tb_cin;
`endif

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: plain unsigned addition, carry-out is bit NB.
  function automatic logic [NB:0] ref_add(input logic [NB-1:0] a, input logic [NB-1:0] b,
                                          input logic c);
    return {1'b0, a} + {1'b0, b} + (NB+1)'(c & CIN_EN);
  endfunction

  // Entered at a falling edge with the DUT idle; leaves at a falling edge
  // with the DUT back in IDLE.
  task automatic do_txn(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic c,
                        input int hold, input string tag,
                        output logic [NB-1:0] got_sum, output logic got_cout);
    int   n;
    logic bad;
    chk({tag, "_idle_rdy"}, 32'(ifc.istream_rdy), 32'd1);
    ifc.istream_in0 = a;
    ifc.istream_in1 = b;
    tb_cin          = c;
    ifc.istream_val = 1'b1;
    ifc.ostream_rdy = 1'b0;
    @(negedge clk);
    ifc.istream_val = 1'b0;
    n   = 1;
    bad = 1'b0;
    while (ifc.ostream_val !== 1'b1 && n < 4*NB + 8) begin
      if (ifc.istream_rdy !== 1'b0) bad = 1'b1;
      // Operands are only sampled on the accepting edge.
      ifc.istream_in0 = NB'($urandom);
      ifc.istream_in1 = NB'($urandom);
      tb_cin          = 1'($urandom);
      @(negedge clk);
      n++;
    end
    chk({tag, "_calc_rdy_low"}, 32'(bad), 32'd0);
    chk({tag, "_latency"}, 32'(n), 32'(NB + 1));
    chk({tag, "_done_rdy_low"}, 32'(ifc.istream_rdy), 32'd0);
    got_sum  = ifc.ostream_sum;
    got_cout = ifc.ostream_cout;
    bad = 1'b0;
    for (int h = 0; h < hold; h++) begin
      ifc.istream_val = 1'b1;
      ifc.istream_in0 = NB'($urandom);
      ifc.istream_in1 = NB'($urandom);
      @(negedge clk);
      if (ifc.ostream_val !== 1'b1 || ifc.ostream_sum !== got_sum ||
          ifc.ostream_cout !== got_cout || ifc.istream_rdy !== 1'b0) bad = 1'b1;
    end
    if (hold > 0) chk({tag, "_hold_stable"}, 32'(bad), 32'd0);
    ifc.istream_val = 1'b0;
    ifc.ostream_rdy = 1'b1;
    @(negedge clk);
    ifc.ostream_rdy = 1'b0;
    chk({tag, "_back_idle"}, {30'd0, ifc.ostream_val, ifc.istream_rdy}, 32'b01);
  endtask

  typedef struct {
    logic [NB-1:0] a;
    logic [NB-1:0] b;
    logic          cin;
    int            hold;
    logic [NB-1:0] sum;
    logic          cout;
  } vec_t;

  vec_t          vecs[7];
  logic [NB-1:0] pa[3];
  logic [NB-1:0] pb[3];
  logic [NB-1:0] ps[3];
  logic          pc[3];

  initial begin
    logic [NB-1:0] gs;
    logic          gc;
    logic [NB:0]   exp;
    logic [NB-1:0] ra, rb;
    logic          rc;
    int            acc[3];
    int            k, r, cyc;

    vecs[0] = '{8'h05, 8'h03, 1'b0, 0, 8'h08, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b0, 0, 8'hFE, 1'b1};
    vecs[3] = '{8'hA5, 8'h5A, 1'b0, 5, 8'hFF, 1'b0};
    vecs[4] = '{8'h10, 8'h20, 1'b0, 1, 8'h30, 1'b0};
`ifdef SERIAL_ADDER_CIN_EN
    vecs[5] = '{8'h7F, 8'h00, 1'b1, 0, 8'h80, 1'b0};
    vecs[6] = '{8'hFF, 8'h00, 1'b1, 2, 8'h00, 1'b1};
`else
    vecs[5] = '{8'h7F, 8'h00, 1'b1, 0, 8'h7F, 1'b0};
    vecs[6] = '{8'hFF, 8'h00, 1'b1, 2, 8'hFF, 1'b0};
`endif
    pa[0] = 8'h01; pb[0] = 8'h02; ps[0] = 8'h03; pc[0] = 1'b0;
    pa[1] = 8'h03; pb[1] = 8'h04; ps[1] = 8'h07; pc[1] = 1'b0;
    pa[2] = 8'h80; pb[2] = 8'h80; ps[2] = 8'h00; pc[2] = 1'b1;

    reset           = 1'b1;
    tb_cin          = 1'b0;
    ifc.istream_val = 1'b0;
    ifc.istream_in0 = '0;
    ifc.istream_in1 = '0;
    ifc.ostream_rdy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_istream_rdy", 32'(ifc.istream_rdy), 32'd1);
    chk("rst_ostream_val", 32'(ifc.ostream_val), 32'd0);
    chk("rst_ostream_sum", 32'(ifc.ostream_sum), 32'd0);
    chk("rst_ostream_cout", 32'(ifc.ostream_cout), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed vectors.
    for (int i = 0; i < 7; i++) begin
      do_txn(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].hold, $sformatf("vec%0d", i), gs, gc);
      chk($sformatf("vec%0d_sum", i), 32'(gs), 32'(vecs[i].sum));
      chk($sformatf("vec%0d_cout", i), 32'(gc), 32'(vecs[i].cout));
    end

    // Back-to-back: operands always offered, result always taken.
    acc[0] = 0; acc[1] = 0; acc[2] = 0;
    k = 0; r = 0; cyc = 0;
    tb_cin          = 1'b0;
    ifc.ostream_rdy = 1'b1;
    ifc.istream_val = 1'b1;
    ifc.istream_in0 = pa[0];
    ifc.istream_in1 = pb[0];
    while (r < 3 && cyc < 200) begin
      if (ifc.istream_val && ifc.istream_rdy && k < 3) begin
        acc[k] = cyc;
        k++;
      end
      if (ifc.ostream_val === 1'b1) begin
        chk($sformatf("b2b%0d_sum", r), 32'(ifc.ostream_sum), 32'(ps[r]));
        chk($sformatf("b2b%0d_cout", r), 32'(ifc.ostream_cout), 32'(pc[r]));
        r++;
      end
      @(negedge clk);
      cyc++;
      if (k < 3) begin
        ifc.istream_in0 = pa[k];
        ifc.istream_in1 = pb[k];
      end else begin
        ifc.istream_val = 1'b0;
      end
    end
    ifc.istream_val = 1'b0;
    ifc.ostream_rdy = 1'b0;
    chk("b2b_results", 32'(r), 32'd3);
    chk("b2b_interval01", 32'(acc[1] - acc[0]), 32'(NB + 2));
    chk("b2b_interval12", 32'(acc[2] - acc[1]), 32'(NB + 2));
    @(negedge clk);

    // Reset wins over istream_val in the same cycle.
    reset           = 1'b1;
    ifc.istream_val = 1'b1;
    ifc.istream_in0 = 8'h11;
    ifc.istream_in1 = 8'h22;
    @(negedge clk);
    reset           = 1'b0;
    ifc.istream_val = 1'b0;
    chk("rst_prio_rdy", 32'(ifc.istream_rdy), 32'd1);

    // Reset during the 4th CALC cycle abandons the transaction.
    ifc.istream_in0 = 8'h12;
    ifc.istream_in1 = 8'h34;
    ifc.istream_val = 1'b1;
    @(negedge clk);
    ifc.istream_val = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_rdy", 32'(ifc.istream_rdy), 32'd1);
    chk("midrst_val", 32'(ifc.ostream_val), 32'd0);
    chk("midrst_sum", 32'(ifc.ostream_sum), 32'd0);
    do_txn(8'h10, 8'h20, 1'b0, 0, "after_rst", gs, gc);
    chk("after_rst_sum", 32'(gs), 32'h30);
    chk("after_rst_cout", 32'(gc), 32'd0);

    // Randomized transactions against the arithmetic model.
    for (int i = 0; i < 25; i++) begin
      ra  = NB'($urandom);
      rb  = NB'($urandom);
      rc  = 1'($urandom_range(0, 1));
      exp = ref_add(ra, rb, rc);
      do_txn(ra, rb, rc, int'($urandom_range(0, 3)), $sformatf("rnd%0d", i), gs, gc);
      chk($sformatf("rnd%0d_sum", i), 32'(gs), 32'(exp[NB-1:0]));
      chk($sformatf("rnd%0d_cout", i), 32'(gc), 32'(exp[NB]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
